vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_axis_ctr.sv | 75 +++++++
 rtl/vga_timing_gen.sv | 122 ++++++++++++
 tb/tb_vga_timing_gen.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared raster-timing types and 1080p defaults for the VGA timing generator.
package vga_pkg;

   typedef enum logic [1:0] {
      PH_ACT  = 2'd0,
      PH_FP   = 2'd1,
      PH_SYNC = 2'd2,
      PH_BP   = 2'd3
   } phase_t;

   localparam int unsigned DEF_H_ACTIVE = 1920;
   localparam int unsigned DEF_H_FP     = 88;
   localparam int unsigned DEF_H_SYNC   = 44;
   localparam int unsigned DEF_H_BP     = 148;
   localparam int unsigned DEF_V_ACTIVE = 1080;
   localparam int unsigned DEF_V_FP     = 4;
   localparam int unsigned DEF_V_SYNC   = 5;
   localparam int unsigned DEF_V_BP     = 36;

   function automatic int unsigned axis_total(
      input int unsigned active,
      input int unsigned fp,
      input int unsigned sync,
      input int unsigned bp
   );
      return active + fp + sync + bp;
   endfunction

   localparam int unsigned DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
   localparam int unsigned DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_axis_ctr.sv
// One raster axis: position counter plus ACT/FP/SYNC/BP phase FSM, stepping on i_advance.
module vga_axis_ctr
   import vga_pkg::*;
#(
   parameter int unsigned ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned FP     = DEF_H_FP,
   parameter int unsigned SYNC   = DEF_H_SYNC,
   parameter int unsigned BP     = DEF_H_BP
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_advance,
   output logic [11:0] o_count,
   output phase_t      o_phase,
   output logic        o_wrap
);

   localparam logic [11:0] LAST_ACT  = 12'(ACTIVE - 1);
   localparam logic [11:0] LAST_FP   = 12'(ACTIVE + FP - 1);
   localparam logic [11:0] LAST_SYNC = 12'(ACTIVE + FP + SYNC - 1);
   localparam logic [11:0] LAST      = 12'(axis_total(ACTIVE, FP, SYNC, BP) - 1);

   phase_t      r_phase;
   phase_t      w_phase_nxt;
   logic [11:0] r_count;
   logic        w_at_end;

   assign w_at_end = (r_count == LAST);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_phase <= PH_ACT;
      end else begin
         r_phase <= w_phase_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_advance) begin
         r_count <= w_at_end ? '0 : r_count + 12'd1;
      end
   end

   always_comb begin
      w_phase_nxt = r_phase;
      if (i_advance) begin
         unique case (r_phase)
            PH_ACT:  if (r_count == LAST_ACT)  w_phase_nxt = PH_FP;
            PH_FP:   if (r_count == LAST_FP)   w_phase_nxt = PH_SYNC;
            PH_SYNC: if (r_count == LAST_SYNC) w_phase_nxt = PH_BP;
            PH_BP:   if (w_at_end)             w_phase_nxt = PH_ACT;
            default:                           w_phase_nxt = PH_ACT;
         endcase
      end
   end

   always_comb begin
      o_count = r_count;
      o_phase = r_phase;
      o_wrap  = i_advance && w_at_end;
   end

   function automatic phase_t range_phase(input logic [11:0] c);
      if (c <= LAST_ACT)  return PH_ACT;
      if (c <= LAST_FP)   return PH_FP;
      if (c <= LAST_SYNC) return PH_SYNC;
      return PH_BP;
   endfunction

   // Phase is tracked separately from the count; the two must never disagree.
   a_phase_matches_count: assert property (@(posedge i_clk) r_phase == range_phase(r_count));

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel divider, H/V axis counters, registered output stage, frame counter.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter int unsigned PIX_DIV  = 1,
   parameter bit          HS_POL   = 1'b1,
   parameter bit          VS_POL   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [11:0] h_count,
   output logic [11:0] v_count,
   output logic        video_on,
   output logic        hsync,
   output logic        vsync,
   output logic        pix_tick,
   output logic        line_start,
   output logic        frame_start,
   output logic [15:0] frame_cnt
);

   localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam logic [3:0]  DIV_LAST = 4'(PIX_DIV - 1);

   if (H_TOTAL > 4095 || V_TOTAL > 4095) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 4095");
   end
   if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_bad_div
      $error("vga_timing_gen: PIX_DIV must be in 1..16");
   end

   logic [3:0]  r_div;
   logic        w_tick;
   logic [11:0] w_hc;
   logic [11:0] w_vc;
   phase_t      w_hph;
   phase_t      w_vph;
   logic        w_h_wrap;
   logic        w_v_wrap;
   logic [15:0] r_frames;

   assign w_tick = (r_div == DIV_LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_div <= '0;
      end else begin
         r_div <= w_tick ? '0 : r_div + 4'd1;
      end
   end

   vga_axis_ctr #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP)
   ) u_h_axis (
      .i_clk     (clk),
      .i_rst_n   (rst),
      .i_advance (w_tick),
      .o_count   (w_hc),
      .o_phase   (w_hph),
      .o_wrap    (w_h_wrap)
   );

   vga_axis_ctr #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP)
   ) u_v_axis (
      .i_clk     (clk),
      .i_rst_n   (rst),
      .i_advance (w_h_wrap),
      .o_count   (w_vc),
      .o_phase   (w_vph),
      .o_wrap    (w_v_wrap)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_frames <= '0;
      end else if (w_v_wrap) begin
         r_frames <= r_frames + 16'd1;
      end
   end

   // Everything below mirrors the counter state one clock late, frame_cnt included.
   always_ff @(posedge clk) begin
      if (!rst) begin
         h_count     <= '0;
         v_count     <= '0;
         video_on    <= 1'b0;
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         pix_tick    <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         h_count     <= w_hc;
         v_count     <= w_vc;
         video_on    <= (w_hph == PH_ACT) && (w_vph == PH_ACT);
         hsync       <= (w_hph == PH_SYNC) ? HS_POL : ~HS_POL;
         vsync       <= (w_vph == PH_SYNC) ? VS_POL : ~VS_POL;
         pix_tick    <= w_tick;
         line_start  <= w_tick && (w_hc == '0);
         frame_start <= w_tick && (w_hc == '0) && (w_vc == '0);
         frame_cnt   <= r_frames;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: constant vector table, hand sequences and a random-reset run against an arithmetic raster model.
module tb_vga_timing_gen;

   typedef struct packed {
      logic [11:0] h;
      logic [11:0] v;
      logic        vid;
      logic        hs;
      logic        vs;
      logic        pt;
      logic        ls;
      logic        fs;
      logic [15:0] fc;
   } obs_t;

   typedef struct {
      int   k;
      obs_t e;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_s, rst_h;
   logic [11:0] h_s, v_s, h_h, v_h;
   logic        vid_s, hs_s, vs_s, pt_s, ls_s, fs_s;
   logic        vid_h, hs_h, vs_h, pt_h, ls_h, fs_h;
   logic [15:0] fc_s, fc_h;

   vga_timing_gen #(
      .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
      .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
      .PIX_DIV  (2), .HS_POL (1'b0), .VS_POL (1'b0)
   ) dut (
      .clk (clk), .rst (rst_s), .h_count (h_s), .v_count (v_s), .video_on (vid_s),
      .hsync (hs_s), .vsync (vs_s), .pix_tick (pt_s), .line_start (ls_s),
      .frame_start (fs_s), .frame_cnt (fc_s)
   );

   vga_timing_gen #(
      .PIX_DIV (1), .HS_POL (1'b1), .VS_POL (1'b1)
   ) dut_hd (
      .clk (clk), .rst (rst_h), .h_count (h_h), .v_count (v_h), .video_on (vid_h),
      .hsync (hs_h), .vsync (vs_h), .pix_tick (pt_h), .line_start (ls_h),
      .frame_start (fs_h), .frame_cnt (fc_h)
   );

   obs_t act_s, act_h;
   assign act_s = {h_s, v_s, vid_s, hs_s, vs_s, pt_s, ls_s, fs_s, fc_s};
   assign act_h = {h_h, v_h, vid_h, hs_h, vs_h, pt_h, ls_h, fs_h, fc_h};

   int checks = 0;
   int errors = 0;
   longint m_s = 0;
   longint m_h = 0;

   function automatic obs_t mk(input int h, input int v, input bit vid, input bit hs, input bit vs,
                               input bit pt, input bit ls, input bit fs, input int fc);
      obs_t o;
      o.h = 12'(h); o.v = 12'(v); o.vid = vid; o.hs = hs; o.vs = vs;
      o.pt = pt; o.ls = ls; o.fs = fs; o.fc = 16'(fc);
      return o;
   endfunction

   // Output after the (m+1)-th running clock shows the raster position reached after m clocks.
   function automatic obs_t model(input longint m, input int ha, input int hfp, input int hsw, input int hbp,
                                  input int va, input int vfp, input int vsw, input int vbp,
                                  input int pd, input bit hpol, input bit vpol);
      longint ht, vt, p, hc, vc, fr;
      bit tick;
      ht = ha + hfp + hsw + hbp;
      vt = va + vfp + vsw + vbp;
      p  = m / pd;
      hc = p % ht;
      vc = (p / ht) % vt;
      fr = (p / (ht * vt)) % 65536;
      tick = ((m % pd) == pd - 1);
      return mk(int'(hc), int'(vc), (hc < ha) && (vc < va),
                (hc >= ha + hfp && hc < ha + hfp + hsw) ? hpol : ~hpol,
                (vc >= va + vfp && vc < va + vfp + vsw) ? vpol : ~vpol,
                tick, tick && hc == 0, tick && hc == 0 && vc == 0, int'(fr));
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("h=%0d v=%0d vid=%0b hs=%0b vs=%0b pt=%0b ls=%0b fs=%0b fc=%0d",
                       o.h, o.v, o.vid, o.hs, o.vs, o.pt, o.ls, o.fs, o.fc);
   endfunction

   task automatic check(input string name, input obs_t act, input obs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick_s(input logic r, output obs_t exp);
      rst_s = r;
      @(posedge clk);
      #1;
      if (!r) begin
         exp = mk(0, 0, 0, 1, 1, 0, 0, 0, 0);
         m_s = 0;
      end else begin
         exp = model(m_s, 8, 2, 3, 3, 4, 1, 2, 1, 2, 1'b0, 1'b0);
         m_s++;
      end
   endtask

   task automatic tick_h(input logic r, output obs_t exp);
      rst_h = r;
      @(posedge clk);
      #1;
      if (!r) begin
         exp = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
         m_h = 0;
      end else begin
         exp = model(m_h, 1920, 88, 44, 148, 1080, 4, 5, 36, 1, 1'b1, 1'b1);
         m_h++;
      end
   endtask

   initial begin
      vec_t tbl[$];
      obs_t e;
      int   ti;
      int   n_ls, n_hs, n_vs, n_fs, n_vid;

      rst_s = 1'b0;
      rst_h = 1'b0;

      // k = running clocks since reset release; small config, PIX_DIV=2, active-low syncs
      tbl.push_back('{k:1,   e:mk(0,  0, 1, 1, 1, 0, 0, 0, 0)});
      tbl.push_back('{k:2,   e:mk(0,  0, 1, 1, 1, 1, 1, 1, 0)});
      tbl.push_back('{k:3,   e:mk(1,  0, 1, 1, 1, 0, 0, 0, 0)});
      tbl.push_back('{k:16,  e:mk(7,  0, 1, 1, 1, 1, 0, 0, 0)});
      tbl.push_back('{k:17,  e:mk(8,  0, 0, 1, 1, 0, 0, 0, 0)});
      tbl.push_back('{k:20,  e:mk(9,  0, 0, 1, 1, 1, 0, 0, 0)});
      tbl.push_back('{k:21,  e:mk(10, 0, 0, 0, 1, 0, 0, 0, 0)});
      tbl.push_back('{k:26,  e:mk(12, 0, 0, 0, 1, 1, 0, 0, 0)});
      tbl.push_back('{k:27,  e:mk(13, 0, 0, 1, 1, 0, 0, 0, 0)});
      tbl.push_back('{k:32,  e:mk(15, 0, 0, 1, 1, 1, 0, 0, 0)});
      tbl.push_back('{k:33,  e:mk(0,  1, 1, 1, 1, 0, 0, 0, 0)});
      tbl.push_back('{k:34,  e:mk(0,  1, 1, 1, 1, 1, 1, 0, 0)});
      tbl.push_back('{k:129, e:mk(0,  4, 0, 1, 1, 0, 0, 0, 0)});
      tbl.push_back('{k:161, e:mk(0,  5, 0, 1, 0, 0, 0, 0, 0)});
      tbl.push_back('{k:224, e:mk(15, 6, 0, 1, 0, 1, 0, 0, 0)});
      tbl.push_back('{k:225, e:mk(0,  7, 0, 1, 1, 0, 0, 0, 0)});
      tbl.push_back('{k:256, e:mk(15, 7, 0, 1, 1, 1, 0, 0, 0)});
      tbl.push_back('{k:257, e:mk(0,  0, 1, 1, 1, 0, 0, 0, 1)});
      tbl.push_back('{k:258, e:mk(0,  0, 1, 1, 1, 1, 1, 1, 1)});

      for (int i = 0; i < 5; i++) begin
         tick_s(1'b0, e);
         check("reset_hold", act_s, mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
      end

      ti = 0;
      n_ls = 0; n_hs = 0; n_vs = 0; n_fs = 0; n_vid = 0;
      for (int k = 1; k <= 258; k++) begin
         tick_s(1'b1, e);
         if (k <= 256) begin
            n_ls  += int'(ls_s);
            n_fs  += int'(fs_s);
            n_vid += int'(vid_s);
            n_hs  += int'(!hs_s);
            n_vs  += int'(!vs_s);
         end
         if (ti < tbl.size() && tbl[ti].k == k) begin
            check($sformatf("vec_k%0d", k), act_s, tbl[ti].e);
            ti++;
         end
      end
      check_int("table_consumed", ti, 19);
      check_int("line_starts_per_frame", n_ls, 8);
      check_int("frame_starts_per_frame", n_fs, 1);
      check_int("video_on_clks", n_vid, 64);
      check_int("hsync_low_clks", n_hs, 48);
      check_int("vsync_low_clks", n_vs, 64);

      for (int k = 259; k <= 333; k++) tick_s(1'b1, e);
      check("midframe_before", act_s, mk(6, 2, 1, 1, 1, 0, 0, 0, 1));
      tick_s(1'b0, e);
      check("midframe_reset", act_s, mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
      tick_s(1'b1, e);
      check("midframe_restart", act_s, mk(0, 0, 1, 1, 1, 0, 0, 0, 0));

      for (int i = 0; i < 3000; i++) begin
         tick_s(($urandom_range(0, 799) != 0) ? 1'b1 : 1'b0, e);
         check("random_model", act_s, e);
      end

      for (int i = 0; i < 2; i++) begin
         tick_h(1'b0, e);
         check("hd_reset", act_h, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      for (int k = 1; k <= 4500; k++) begin
         tick_h(1'b1, e);
         check("hd_model", act_h, e);
         if (k == 1)    check("hd_first",      act_h, mk(0,    0, 1, 0, 0, 1, 1, 1, 0));
         if (k == 2008) check("hd_hsync_pre",  act_h, mk(2007, 0, 0, 0, 0, 1, 0, 0, 0));
         if (k == 2009) check("hd_hsync_on",   act_h, mk(2008, 0, 0, 1, 0, 1, 0, 0, 0));
         if (k == 2053) check("hd_hsync_off",  act_h, mk(2052, 0, 0, 0, 0, 1, 0, 0, 0));
         if (k == 2201) check("hd_line2",      act_h, mk(0,    1, 1, 0, 0, 1, 1, 0, 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
